// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - two-entry/two-exit gate arbiter in front of the parking core
//
// Serialises gate transactions towards the parking core. Entry requests are
// admitted only when the matching section flag shows room; exits are always
// forwarded. Each accepted transaction drives a PULSE_CYCLES-long core pulse,
// waits SETTLE_CYCLES so the core can refresh its space flags, then returns a
// one-cycle response to the gate.
//
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   ent_req[1:0], ent_is_uni     entry gate requests and car class (1 = university)
//   ext_req[1:0], ext_is_uni     exit gate requests and car class
//   uni_is_vacated_space         core flag: university section has room
//   free_is_vacated_space        core flag: free section has room
//   car_entered, is_uni_car_entered  entry pulse and class to the core
//   car_exited, is_uni_car_exited    exit pulse and class to the core
//   ent_grant, ent_deny, ext_done    one-cycle per-gate responses
//   busy                         high whenever the arbiter is not idle
module parking_gate_arbiter #(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] ent_req,
  input  logic [1:0] ent_is_uni,
  input  logic [1:0] ext_req,
  input  logic [1:0] ext_is_uni,
  input  logic       uni_is_vacated_space,
  input  logic       free_is_vacated_space,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic [1:0] ent_grant,
  output logic [1:0] ent_deny,
  output logic [1:0] ext_done,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, RESP} state_t;

  localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYCLES);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [3:0] phase_cnt;
  logic       sel_exit;    // class of the transaction in flight
  logic       sel_gate;    // gate of the transaction in flight
  logic       last_exit;   // class served last: 1 = exit
  logic       rr_ent;      // entry round-robin pointer
  logic       rr_ext;      // exit round-robin pointer
  logic       just_resp;   // first IDLE cycle after a response

  logic [1:0] ent_avail;
  logic [1:0] ext_avail;
  logic [1:0] pick_req;
  logic       pick_exit;
  logic       pick_ptr;
  logic       pick_gate;
  logic       pick_uni;
  logic       pick_room;
  logic [1:0] pick_onehot;
  logic [1:0] sel_onehot;

  always_comb begin
    ent_avail = ent_req;
    ext_avail = ext_req;
    // The gate just answered may still show its old request in this cycle;
    // it must not be served twice for one car.
    if (just_resp) begin
      if (sel_exit) ext_avail[sel_gate] = 1'b0;
      else          ent_avail[sel_gate] = 1'b0;
    end
    pick_exit   = (|ext_avail) && (!(|ent_avail) || !last_exit);
    pick_req    = pick_exit ? ext_avail : ent_avail;
    pick_ptr    = pick_exit ? rr_ext : rr_ent;
    pick_gate   = pick_req[pick_ptr] ? pick_ptr : ~pick_ptr;
    pick_uni    = pick_exit ? ext_is_uni[pick_gate] : ent_is_uni[pick_gate];
    pick_room   = pick_uni ? uni_is_vacated_space : free_is_vacated_space;
    pick_onehot = pick_gate ? 2'b10 : 2'b01;
    sel_onehot  = sel_gate ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      phase_cnt          <= 4'd0;
      sel_exit           <= 1'b0;
      sel_gate           <= 1'b0;
      last_exit          <= 1'b1;
      rr_ent             <= 1'b0;
      rr_ext             <= 1'b0;
      just_resp          <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      ent_grant          <= 2'b00;
      ent_deny           <= 2'b00;
      ext_done           <= 2'b00;
      busy               <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          just_resp <= 1'b0;
          if ((|ent_avail) || (|ext_avail)) begin
            sel_exit <= pick_exit;
            sel_gate <= pick_gate;
            busy     <= 1'b1;
            // Space is judged on the flags seen now; the core cannot change
            // them under us until it has seen our pulse.
            if (!pick_exit && !pick_room) begin
              state    <= RESP;
              ent_deny <= pick_onehot;
            end else begin
              state     <= PULSE;
              phase_cnt <= 4'd1;
              if (pick_exit) begin
                car_exited        <= 1'b1;
                is_uni_car_exited <= pick_uni;
              end else begin
                car_entered        <= 1'b1;
                is_uni_car_entered <= pick_uni;
              end
            end
          end
        end
        PULSE: begin
          if (phase_cnt == PULSE_LAST) begin
            state              <= SETTLE;
            phase_cnt          <= 4'd1;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            car_exited         <= 1'b0;
            is_uni_car_exited  <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        SETTLE: begin
          if (phase_cnt == SETTLE_LAST) begin
            state     <= RESP;
            phase_cnt <= 4'd0;
            if (sel_exit) ext_done  <= sel_onehot;
            else          ent_grant <= sel_onehot;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          ent_grant <= 2'b00;
          ent_deny  <= 2'b00;
          ext_done  <= 2'b00;
          just_resp <= 1'b1;
          last_exit <= sel_exit;
          if (sel_exit) rr_ext <= ~sel_gate;
          else          rr_ent <= ~sel_gate;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - randomized self-checking bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

  localparam int P = 2;
  localparam int S = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] ent_req = '0, ent_is_uni = '0, ext_req = '0, ext_is_uni = '0;
  logic       uni_is_vacated_space = 1'b0, free_is_vacated_space = 1'b0;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, busy;
  logic [1:0] ent_grant, ent_deny, ext_done;

  parking_gate_arbiter #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .clock(clock), .reset(reset),
    .ent_req(ent_req), .ent_is_uni(ent_is_uni),
    .ext_req(ext_req), .ext_is_uni(ext_is_uni),
    .uni_is_vacated_space(uni_is_vacated_space),
    .free_is_vacated_space(free_is_vacated_space),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .ent_grant(ent_grant), .ent_deny(ent_deny), .ext_done(ext_done),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: one transaction record, timed with plain arithmetic.
  bit t_active, t_exit, t_uni, t_deny;
  int t_start, t_resp, t_gate;
  bit m_ptr_ent, m_ptr_ext, m_last_exit;
  bit mask_v, mask_exit;
  int mask_gate;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int g);
    return (g != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    t_active = 0; m_ptr_ent = 0; m_ptr_ext = 0; m_last_exit = 1; mask_v = 0;
  endtask

  function automatic logic [10:0] expected();
    logic b, ce, cu, xe, xu;
    logic [1:0] eg, ed, xd;
    {b, ce, cu, xe, xu, eg, ed, xd} = '0;
    if (!reset && t_active && cyc >= t_start) begin
      b = 1'b1;
      if (t_deny) begin
        if (cyc == t_resp) ed = onehot(t_gate);
      end else begin
        if (cyc < t_start + P) begin
          if (t_exit) begin xe = 1'b1; xu = t_uni; end
          else        begin ce = 1'b1; cu = t_uni; end
        end
        if (cyc == t_resp) begin
          if (t_exit) xd = onehot(t_gate);
          else        eg = onehot(t_gate);
        end
      end
    end
    return {b, ce, cu, xe, xu, eg, ed, xd};
  endfunction

  function automatic logic [10:0] observed();
    if (reset)
      return {busy, car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
              ent_grant, ent_deny, ext_done};
    return {busy, car_entered, car_entered & is_uni_car_entered,
            car_exited, car_exited & is_uni_car_exited, ent_grant, ent_deny, ext_done};
  endfunction

  task automatic check_cycle();
    @(negedge clock);
    cyc++;
    check("outputs", 32'(observed()), 32'(expected()));
  endtask

  // Model of the posedge that ends the current cycle, from the inputs now applied.
  task automatic model_update();
    logic [1:0] er, xr, r;
    bit ch_exit;
    int p, g;
    if (reset) return;
    if (t_active && cyc == t_resp) begin
      if (t_exit) m_ptr_ext = (t_gate == 0);
      else        m_ptr_ent = (t_gate == 0);
      m_last_exit = t_exit;
      mask_v = 1; mask_exit = t_exit; mask_gate = t_gate;
      t_active = 0;
    end else if (!t_active) begin
      er = ent_req; xr = ext_req;
      if (mask_v) begin
        if (mask_exit) xr[mask_gate] = 1'b0;
        else           er[mask_gate] = 1'b0;
      end
      mask_v = 0;
      if (er != 0 || xr != 0) begin
        ch_exit = (xr != 0) && (er == 0 || !m_last_exit);
        r = ch_exit ? xr : er;
        p = ch_exit ? int'(m_ptr_ext) : int'(m_ptr_ent);
        g = r[p] ? p : 1 - p;
        t_active = 1; t_start = cyc + 1; t_exit = ch_exit; t_gate = g;
        t_uni  = ch_exit ? ext_is_uni[g] : ent_is_uni[g];
        t_deny = !ch_exit && !(t_uni ? uni_is_vacated_space : free_is_vacated_space);
        t_resp = t_deny ? t_start : t_start + P + S;
      end
    end
  endtask

  // Requesters drop their request in their response cycle.
  task automatic end_cycle();
    if (!reset && t_active && cyc == t_resp) begin
      if (t_exit) ext_req[t_gate] = 1'b0;
      else        ent_req[t_gate] = 1'b0;
    end
    model_update();
  endtask

  // mode 0: no new requests, 1: random traffic, 2: exits re-raised, 3: all re-raised
  task automatic drive(input int mode);
    for (int g = 0; g < 2; g++) begin
      bit act_ent, act_ext;
      act_ent = t_active && !t_exit && t_gate == g;
      act_ext = t_active && t_exit && t_gate == g;
      if (!ent_req[g] && !act_ent &&
          (mode == 3 || (mode == 1 && $urandom_range(3) == 0))) begin
        ent_req[g] = 1'b1;
        ent_is_uni[g] = 1'($urandom);
      end
      if (!ext_req[g] && !act_ext &&
          (mode >= 2 || (mode == 1 && $urandom_range(3) == 0))) begin
        ext_req[g] = 1'b1;
        ext_is_uni[g] = 1'($urandom);
      end
    end
    if (mode == 1) begin
      if (t_active && cyc < t_resp && $urandom_range(7) == 0) begin
        if (t_exit) ext_req[t_gate] = 1'b0;
        else        ent_req[t_gate] = 1'b0;
      end
      uni_is_vacated_space  = ($urandom_range(3) != 0);
      free_is_vacated_space = ($urandom_range(3) != 0);
    end
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      check_cycle();
      drive(mode);
      end_cycle();
    end
  endtask

  // Leaves reset high and inputs idle; the caller releases it in a check window.
  task automatic enter_reset(input int n);
    check_cycle();
    reset = 1'b1;
    ent_req = '0; ext_req = '0;
    model_reset();
    for (int i = 0; i < n; i++) check_cycle();
  endtask

  initial begin
    bit hit;
    model_reset();
    // reset state
    for (int i = 0; i < 3; i++) check_cycle();
    check_cycle();
    reset = 1'b0;
    end_cycle();

    // single granted university entry at gate 0
    check_cycle();
    uni_is_vacated_space = 1'b1; free_is_vacated_space = 1'b1;
    ent_is_uni = 2'b01; ent_req = 2'b01;
    end_cycle();
    run(9, 0);

    // free entry at gate 1 with the free section full -> denied
    check_cycle();
    free_is_vacated_space = 1'b0;
    ent_is_uni = 2'b00; ent_req = 2'b10;
    end_cycle();
    run(5, 0);

    // both exits held: gates alternate
    check_cycle();
    free_is_vacated_space = 1'b1;
    ext_is_uni = 2'($urandom); ext_req = 2'b11;
    end_cycle();
    run(20, 2);
    run(10, 0);

    // entry and exit together from reset, kept pending
    enter_reset(2);
    check_cycle();
    reset = 1'b0;
    uni_is_vacated_space = 1'b1; free_is_vacated_space = 1'b1;
    ent_is_uni = 2'b00; ext_is_uni = 2'b10;
    ent_req = 2'b01; ext_req = 2'b01;
    end_cycle();
    run(30, 3);
    run(30, 0);

    // reset in the middle of an entry pulse
    check_cycle();
    ent_is_uni = 2'b01; ent_req = 2'b01;
    end_cycle();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      check_cycle();
      if (t_active && !t_exit && !t_deny && cyc == t_start) hit = 1;
      else end_cycle();
    end
    check("pulse_reached", 32'(hit), 32'd1);
    #2 reset = 1'b1;
    #1 check("async_reset", 32'({busy, car_entered, car_exited, ent_grant, ent_deny, ext_done}), 32'd0);
    model_reset();
    check_cycle();
    reset = 1'b0;
    end_cycle();
    run(10, 0);

    // random traffic
    run(3000, 1);
    run(20, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
